hetic_nest_ctrl: RTL and testbench

- Sits between the HETI interrupt controller's arbiter outputs and the core interrupt interface.
- Decides whether the current highest-priority pending line may be offered to the core, given the running preemption level and the nest permission of the handler in progress.
- Runs the offer/accept handshake with the core, issues the claim (ack + id) back to the controller, and keeps a hardware stack of active levels that pops on mret.

---
 rtl/hetic_nest_ctrl.sv | 151 +++++++++++++++
 tb/tb_hetic_nest_ctrl.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hetic_nest_ctrl.sv
// rtl/hetic_nest_ctrl.sv - HETI nesting/preemption gate, core offer/claim handshake and active-level stack
// Optional HETIC_NEST_PERF_EN adds saturating taken/preempt counters.
module hetic_nest_ctrl #(
  parameter int NrIrqLines = 64,
  parameter int NrIrqPrios = 32,
  parameter int StackDepth = 4,
  localparam int IrqWidth   = $clog2(NrIrqLines),
  localparam int PrioWidth  = $clog2(NrIrqPrios),
  localparam int DepthWidth = $clog2(StackDepth + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  irq_valid_i,
  input  logic [IrqWidth-1:0]   irq_id_i,
  input  logic [PrioWidth-1:0]  irq_level_i,
  input  logic                  irq_heti_i,
  input  logic                  irq_nest_i,
  output logic                  core_irq_req_o,
  output logic [IrqWidth-1:0]   core_irq_id_o,
  output logic [PrioWidth-1:0]  core_irq_level_o,
  output logic                  core_irq_heti_o,
  input  logic                  core_irq_ack_i,
  input  logic                  core_mret_i,
  output logic                  hetic_ack_o,
  output logic [IrqWidth-1:0]   hetic_ack_id_o,
  output logic [PrioWidth-1:0]  thresh_o,
  output logic [DepthWidth-1:0] depth_o,
  output logic                  err_o
`ifdef HETIC_NEST_PERF_EN
  ,
  output logic [15:0]           perf_taken_o,
  output logic [15:0]           perf_preempt_o
`endif
);

  // Stack array sized to the full depth-index range so depth can index it directly.
  localparam int StkSize = 1 << DepthWidth;

  typedef enum logic [1:0] {IDLE, OFFER, CLAIM} state_e;

  state_e                state_q;
  logic [PrioWidth-1:0]  stk_lvl_q [StkSize];
  logic                  stk_nest_q [StkSize];
  logic [DepthWidth-1:0] depth_q, depth_d, depth_pop, top_idx;
  logic [PrioWidth-1:0]  thresh;
  logic                  top_nest, eligible, do_pop, do_push;
  logic                  req_q, heti_q, nest_q, ack_q, err_q;
  logic [IrqWidth-1:0]   id_q, ack_id_q;
  logic [PrioWidth-1:0]  lvl_q;

  always_comb begin
    top_idx   = depth_q - DepthWidth'(1);
    thresh    = (depth_q != '0) ? stk_lvl_q[top_idx] : '0;
    top_nest  = (depth_q != '0) ? stk_nest_q[top_idx] : 1'b0;
    eligible  = irq_valid_i && (irq_level_i > thresh) &&
                ((depth_q == '0) || top_nest) &&
                (depth_q < DepthWidth'(StackDepth));
    do_pop    = core_mret_i && (depth_q != '0);
    do_push   = (state_q == OFFER) && core_irq_ack_i;
    // mret and ack together: pop first, then push into the freed slot.
    depth_pop = do_pop ? top_idx : depth_q;
    depth_d   = do_push ? depth_pop + DepthWidth'(1) : depth_pop;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      req_q    <= 1'b0;
      id_q     <= '0;
      lvl_q    <= '0;
      heti_q   <= 1'b0;
      nest_q   <= 1'b0;
      ack_q    <= 1'b0;
      ack_id_q <= '0;
      err_q    <= 1'b0;
      depth_q  <= '0;
      for (int i = 0; i < StkSize; i++) begin
        stk_lvl_q[i]  <= '0;
        stk_nest_q[i] <= 1'b0;
      end
    end else begin
      ack_q   <= 1'b0;
      depth_q <= depth_d;
      if (core_mret_i && (depth_q == '0)) err_q <= 1'b1;
      if (do_push) begin
        stk_lvl_q[depth_pop]  <= lvl_q;
        stk_nest_q[depth_pop] <= nest_q;
      end
      case (state_q)
        IDLE: begin
          if (eligible) begin
            id_q    <= irq_id_i;
            lvl_q   <= irq_level_i;
            heti_q  <= irq_heti_i;
            nest_q  <= irq_nest_i;
            req_q   <= 1'b1;
            state_q <= OFFER;
          end
        end
        OFFER: begin
          if (core_irq_ack_i) begin
            ack_q    <= 1'b1;
            ack_id_q <= id_q;
            req_q    <= 1'b0;
            state_q  <= CLAIM;
          end else if (eligible && (irq_id_i != id_q)) begin
            id_q   <= irq_id_i;
            lvl_q  <= irq_level_i;
            heti_q <= irq_heti_i;
            nest_q <= irq_nest_i;
          end else if (!eligible) begin
            req_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        // Arbiter output is stale during the claim cycle; nothing is offered here.
        CLAIM:   state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef HETIC_NEST_PERF_EN
  logic [15:0] perf_taken_q, perf_preempt_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      perf_taken_q   <= '0;
      perf_preempt_q <= '0;
    end else if (do_push) begin
      if (perf_taken_q != 16'hFFFF) perf_taken_q <= perf_taken_q + 16'd1;
      if ((depth_q != '0) && (perf_preempt_q != 16'hFFFF))
        perf_preempt_q <= perf_preempt_q + 16'd1;
    end
  end

  assign perf_taken_o   = perf_taken_q;
  assign perf_preempt_o = perf_preempt_q;
`endif

  assign core_irq_req_o   = req_q;
  assign core_irq_id_o    = id_q;
  assign core_irq_level_o = lvl_q;
  assign core_irq_heti_o  = heti_q;
  assign hetic_ack_o      = ack_q;
  assign hetic_ack_id_o   = ack_id_q;
  assign thresh_o         = thresh;
  assign depth_o          = depth_q;
  assign err_o            = err_q;

endmodule

// File: tb/tb_hetic_nest_ctrl.sv
// tb/tb_hetic_nest_ctrl.sv - scoreboard bench for hetic_nest_ctrl
// Claims expected on hetic_ack_o are queued when ack is driven and checked by a monitor.
module tb_hetic_nest_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       irq_valid = 1'b0;
  logic [5:0] irq_id = '0;
  logic [4:0] irq_level = '0;
  logic       irq_heti = 1'b0;
  logic       irq_nest = 1'b0;
  logic       core_ack = 1'b0;
  logic       core_mret = 1'b0;
  logic       req;
  logic [5:0] req_id;
  logic [4:0] req_level;
  logic       req_heti;
  logic       hack;
  logic [5:0] hack_id;
  logic [4:0] thresh;
  logic [2:0] depth;
  logic       err;
`ifdef HETIC_NEST_PERF_EN
  logic [15:0] perf_taken, perf_preempt;
`endif

  int n_cmp = 0;
  int n_bad = 0;
  logic [5:0] exp_q[$];

  hetic_nest_ctrl dut (
    .clk_i(clk), .rst_ni(rst_n),
    .irq_valid_i(irq_valid), .irq_id_i(irq_id), .irq_level_i(irq_level),
    .irq_heti_i(irq_heti), .irq_nest_i(irq_nest),
    .core_irq_req_o(req), .core_irq_id_o(req_id), .core_irq_level_o(req_level),
    .core_irq_heti_o(req_heti), .core_irq_ack_i(core_ack), .core_mret_i(core_mret),
    .hetic_ack_o(hack), .hetic_ack_id_o(hack_id),
    .thresh_o(thresh), .depth_o(depth), .err_o(err)
`ifdef HETIC_NEST_PERF_EN
    , .perf_taken_o(perf_taken), .perf_preempt_o(perf_preempt)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && hack) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL claim_unexpected: hetic_ack_id=%0d, required no claim", hack_id);
      end else begin
        logic [5:0] e;
        e = exp_q.pop_front();
        if (hack_id !== e) begin
          n_bad++;
          $display("FAIL claim_id: got %0d, required %0d", hack_id, e);
        end
      end
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_irq(input logic v, input logic [5:0] id, input logic [4:0] lvl, input logic nest);
    irq_valid = v; irq_id = id; irq_level = lvl; irq_nest = nest; irq_heti = id[0];
  endtask

  task automatic mret();
    core_mret = 1'b1;
    step();
    core_mret = 1'b0;
  endtask

  task automatic offer_and_ack(input logic [5:0] id, input logic [4:0] lvl, input logic nest);
    set_irq(1'b1, id, lvl, nest);
    step();
    n_cmp++;
    if (req !== 1'b1 || req_id !== id || req_level !== lvl) begin
      n_bad++;
      $display("FAIL offer_%0d: req=%0b id=%0d lvl=%0d, required 1/%0d/%0d", id, req, req_id, req_level, id, lvl);
    end
    core_ack = 1'b1;
    exp_q.push_back(id);
    step();
    core_ack = 1'b0;
    set_irq(1'b0, '0, '0, 1'b0);
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step();
    n_cmp++;
    if ({req, req_id, req_level, req_heti, hack, hack_id, thresh, depth, err} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: req=%0b id=%0d hack=%0b thresh=%0d depth=%0d err=%0b, required all 0",
               req, req_id, hack, thresh, depth, err);
    end
  endtask

  task automatic test_single();
    offer_and_ack(6'd5, 5'd3, 1'b0);
    n_cmp++;
    if (thresh !== 5'd3 || depth !== 3'd1 || req !== 1'b0) begin
      n_bad++;
      $display("FAIL single_stack: thresh=%0d depth=%0d req=%0b, required 3/1/0", thresh, depth, req);
    end
  endtask

  task automatic test_nonnest_and_withdraw();
    set_irq(1'b1, 6'd9, 5'd7, 1'b0);
    step(3);
    n_cmp++;
    if (req !== 1'b0) begin
      n_bad++;
      $display("FAIL nonnest_block: req=%0b, required 0", req);
    end
    mret();
    n_cmp++;
    if (depth !== 3'd0 || thresh !== 5'd0) begin
      n_bad++;
      $display("FAIL nonnest_mret: depth=%0d thresh=%0d, required 0/0", depth, thresh);
    end
    step();
    n_cmp++;
    if (req !== 1'b1 || req_id !== 6'd9) begin
      n_bad++;
      $display("FAIL nonnest_offer: req=%0b id=%0d, required 1/9", req, req_id);
    end
    set_irq(1'b0, '0, '0, 1'b0);
    step();
    n_cmp++;
    if (req !== 1'b0) begin
      n_bad++;
      $display("FAIL withdraw: req=%0b, required 0", req);
    end
    step(2);
  endtask

  task automatic test_preempt();
    offer_and_ack(6'd5, 5'd3, 1'b1);
    offer_and_ack(6'd9, 5'd7, 1'b0);
    n_cmp++;
    if (depth !== 3'd2 || thresh !== 5'd7) begin
      n_bad++;
      $display("FAIL preempt_push: depth=%0d thresh=%0d, required 2/7", depth, thresh);
    end
    mret();
    n_cmp++;
    if (depth !== 3'd1 || thresh !== 5'd3) begin
      n_bad++;
      $display("FAIL preempt_pop1: depth=%0d thresh=%0d, required 1/3", depth, thresh);
    end
    mret();
    n_cmp++;
    if (depth !== 3'd0 || thresh !== 5'd0) begin
      n_bad++;
      $display("FAIL preempt_pop2: depth=%0d thresh=%0d, required 0/0", depth, thresh);
    end
  endtask

  task automatic test_replace();
    set_irq(1'b1, 6'd5, 5'd3, 1'b0);
    step();
    set_irq(1'b1, 6'd12, 5'd6, 1'b0);
    step();
    n_cmp++;
    if (req !== 1'b1 || req_id !== 6'd12 || req_level !== 5'd6) begin
      n_bad++;
      $display("FAIL replace: req=%0b id=%0d lvl=%0d, required 1/12/6", req, req_id, req_level);
    end
    set_irq(1'b1, 6'd20, 5'd9, 1'b0);
    core_ack = 1'b1;
    exp_q.push_back(6'd12);
    step();
    core_ack = 1'b0;
    set_irq(1'b0, '0, '0, 1'b0);
    n_cmp++;
    if (hack !== 1'b1 || thresh !== 5'd6) begin
      n_bad++;
      $display("FAIL replace_ack: hack=%0b thresh=%0d, required 1/6", hack, thresh);
    end
    step();
    mret();
    step();
  endtask

  task automatic test_overflow_err();
    for (int i = 1; i <= 4; i++) offer_and_ack(6'(i), 5'(2 * i), 1'b1);
    set_irq(1'b1, 6'd30, 5'd31, 1'b0);
    step(3);
    n_cmp++;
    if (req !== 1'b0 || depth !== 3'd4 || thresh !== 5'd8) begin
      n_bad++;
      $display("FAIL full_block: req=%0b depth=%0d thresh=%0d, required 0/4/8", req, depth, thresh);
    end
    mret();
    step();
    n_cmp++;
    if (req !== 1'b1 || req_id !== 6'd30 || depth !== 3'd3) begin
      n_bad++;
      $display("FAIL full_release: req=%0b id=%0d depth=%0d, required 1/30/3", req, req_id, depth);
    end
    set_irq(1'b0, '0, '0, 1'b0);
    step(2);
    for (int i = 0; i < 3; i++) mret();
    n_cmp++;
    if (depth !== 3'd0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL drain: depth=%0d err=%0b, required 0/0", depth, err);
    end
    mret();
    step(3);
    n_cmp++;
    if (err !== 1'b1 || depth !== 3'd0) begin
      n_bad++;
      $display("FAIL err_sticky: err=%0b depth=%0d, required 1/0", err, depth);
    end
  endtask

  task automatic test_reset_in_claim();
    set_irq(1'b1, 6'd7, 5'd4, 1'b1);
    step();
    core_ack = 1'b1;
    step();
    core_ack = 1'b0;
    set_irq(1'b0, '0, '0, 1'b0);
    n_cmp++;
    if (hack !== 1'b1 || hack_id !== 6'd7) begin
      n_bad++;
      $display("FAIL claim_before_reset: hack=%0b id=%0d, required 1/7", hack, hack_id);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (hack !== 1'b0 || req !== 1'b0 || depth !== 3'd0 || thresh !== 5'd0 || err !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset: hack=%0b req=%0b depth=%0d thresh=%0d err=%0b, required all 0",
               hack, req, depth, thresh, err);
    end
    step();
    rst_n = 1'b1;
    step(2);
  endtask

  initial begin
    test_reset();
    test_single();
    test_nonnest_and_withdraw();
    test_preempt();
    test_replace();
    test_overflow_err();
    test_reset_in_claim();
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL claims_outstanding: %0d left, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
